// File: rtl/multiplier_nbits_sequential.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, unsigned or
// two's-complement mode per operation, valid/ready handshakes on both sides.
// Signed operands are reduced to magnitudes on accept; the sign is applied
// once in FIX, so the CALC datapath is purely unsigned.
module multiplier_nbits_sequential #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_a = (is_signed && A[WIDTH-1]) ? -A : A;
        mag_b = (is_signed && B[WIDTH-1]) ? -B : B;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (cnt == CW'(1)) state_next = FIX;
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, one shift-add step per CALC cycle, sign fix-up in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
                        neg    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    end
                end
                CALC: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                end
                FIX: begin
                    product <= neg ? -acc : acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_nbits_sequential.sv
// Bench for multiplier_nbits_sequential: WIDTH=4 and WIDTH=8 instances share
// one stimulus bus; sel picks which instance is active.
module tb_multiplier_nbits_sequential;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic        sgn;
    logic        ordy;
    logic        sel;
    logic [7:0]  a;
    logic [7:0]  b;

    logic        ir4, ov4, ir8, ov8;
    logic [7:0]  p4;
    logic [15:0] p8;

    logic        ir, ov;
    logic [15:0] prod;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multiplier_nbits_sequential #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv & ~sel), .in_ready(ir4),
        .A(a[3:0]), .B(b[3:0]), .is_signed(sgn),
        .out_valid(ov4), .out_ready(ordy), .product(p4)
    );

    multiplier_nbits_sequential #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv & sel), .in_ready(ir8),
        .A(a), .B(b), .is_signed(sgn),
        .out_valid(ov8), .out_ready(ordy), .product(p8)
    );

    assign ir   = sel ? ir8 : ir4;
    assign ov   = sel ? ov8 : ov4;
    assign prod = sel ? p8 : {8'h00, p4};

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] x,
                                            input logic [7:0] y, input logic s);
        longint m, xv, yv, p;
        m  = (longint'(1) << w) - 1;
        xv = longint'(x) & m;
        yv = longint'(y) & m;
        if (s && x[w-1]) xv = xv - (longint'(1) << w);
        if (s && y[w-1]) yv = yv - (longint'(1) << w);
        p = (xv * yv) & ((longint'(1) << (2 * w)) - 1);
        return p[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; sgn = 1'b0; a = '0; b = '0; sel = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++; if (ir4 !== 1'b1) $display("FAIL reset_in_ready4: got %b expected 1", ir4);
        checks++; if (ov4 !== 1'b0) $display("FAIL reset_out_valid4: got %b expected 0", ov4);
        checks++; if (p4 !== 8'h00) $display("FAIL reset_product4: got %h expected 00", p4);
        checks++; if (ir8 !== 1'b1) $display("FAIL reset_in_ready8: got %b expected 1", ir8);
        checks++; if (ov8 !== 1'b0) $display("FAIL reset_out_valid8: got %b expected 0", ov8);
        checks++; if (p8 !== 16'h0000) $display("FAIL reset_product8: got %h expected 0000", p8);
        errors += (ir4 !== 1'b1) + (ov4 !== 1'b0) + (p4 !== 8'h00)
                + (ir8 !== 1'b1) + (ov8 !== 1'b0) + (p8 !== 16'h0000);
    endtask

    // One full operation with out_ready high: latency, busy in_ready, product, return to IDLE.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                         input logic [15:0] exp, input string name);
        int n;
        int w;
        w = sel ? 8 : 4;
        ordy = 1'b1; a = x; b = y; sgn = s; iv = 1'b1;
        n = 0;
        while (!ir && n < 50) begin step(); n++; end
        checks++;
        if (!ir) begin
            errors++; $display("FAIL %s_wait_ready: got in_ready=0 expected 1", name);
            iv = 1'b0;
            return;
        end
        step();
        iv = 1'b0; a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
        n = 0;
        while (!ov && n < 50) begin
            checks++;
            if (ir !== 1'b0) begin errors++; $display("FAIL %s_busy_in_ready: got %b expected 0", name, ir); end
            step(); n++;
        end
        checks++;
        if (n != w + 1) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, n, w + 1); end
        checks++;
        if (prod !== exp) begin errors++; $display("FAIL %s_product: got %h expected %h", name, prod, exp); end
        checks++;
        if (ir !== 1'b0) begin errors++; $display("FAIL %s_done_in_ready: got %b expected 0", name, ir); end
        step();
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++; $display("FAIL %s_handshake: got out_valid=%b in_ready=%b expected 0/1", name, ov, ir);
        end
    endtask

    task automatic test_unsigned4();
        sel = 1'b0;
        do_op(8'd2, 8'd3, 1'b0, 16'd6, "u4_2x3");
        do_op(8'd10, 8'd3, 1'b0, 16'd30, "u4_10x3");
        do_op(8'd13, 8'd10, 1'b0, 16'd130, "u4_13x10");
    endtask

    task automatic test_signed4();
        sel = 1'b0;
        do_op(8'h0D, 8'h0A, 1'b1, 16'h0012, "s4_m3xm6");
        do_op(8'h08, 8'h08, 1'b1, 16'h0040, "s4_m8xm8");
        do_op(8'h07, 8'h08, 1'b1, 16'h00C8, "s4_7xm8");
        do_op(8'h00, 8'h09, 1'b1, 16'h0000, "s4_0xm7");
    endtask

    task automatic test_backpressure();
        int n;
        sel = 1'b0; ordy = 1'b0; a = 8'd13; b = 8'd10; sgn = 1'b0; iv = 1'b1;
        n = 0;
        while (!ir && n < 50) begin step(); n++; end
        step();
        iv = 1'b0;
        n = 0;
        while (!ov && n < 50) begin step(); n++; end
        iv = 1'b1; a = 8'd1; b = 8'd1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ov !== 1'b1 || prod !== 16'd130 || ir !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: got out_valid=%b product=%0d in_ready=%b expected 1/130/0", ov, prod, ir);
            end
            step();
        end
        ordy = 1'b1;
        checks++;
        if (ov !== 1'b1 || prod !== 16'd130) begin
            errors++; $display("FAIL bp_before_release: got out_valid=%b product=%0d expected 1/130", ov, prod);
        end
        step();
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++; $display("FAIL bp_handshake: got out_valid=%b in_ready=%b expected 0/1", ov, ir);
        end
        step();
        iv = 1'b0;
        checks++;
        if (ir !== 1'b0) begin errors++; $display("FAIL bp_accept_next: got in_ready=%b expected 0", ir); end
        n = 0;
        while (!ov && n < 50) begin step(); n++; end
        checks++;
        if (prod !== 16'd1 || n != 5) begin
            errors++; $display("FAIL bp_second_result: got product=%0d latency=%0d expected 1/5", prod, n);
        end
        step();
    endtask

    task automatic test_reset_midop();
        int n;
        sel = 1'b0; ordy = 1'b1; a = 8'd15; b = 8'd15; sgn = 1'b0; iv = 1'b1;
        n = 0;
        while (!ir && n < 50) begin step(); n++; end
        step();
        iv = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ov !== 1'b0 || prod !== 16'd0 || ir !== 1'b1) begin
            errors++;
            $display("FAIL rst_midop: got out_valid=%b product=%0d in_ready=%b expected 0/0/1", ov, prod, ir);
        end
        do_op(8'd3, 8'd5, 1'b0, 16'd15, "rst_then_3x5");
    endtask

    task automatic test_width8();
        sel = 1'b1;
        do_op(8'hFF, 8'hFF, 1'b0, 16'd65025, "w8_255x255");
        do_op(8'h80, 8'h80, 1'b1, 16'h4000, "w8_m128xm128");
        do_op(8'h80, 8'h7F, 1'b1, 16'hC080, "w8_m128x127");
    endtask

    task automatic test_random(input logic s8, input int num);
        logic [15:0] q[$];
        int issued, done, cyc, w;
        sel = s8; w = s8 ? 8 : 4;
        issued = 0; done = 0; cyc = 0;
        while (done < num && cyc < num * 40) begin
            iv   = (issued < num) && ($urandom_range(0, 2) != 0);
            a    = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            if (ov && q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rand_w%0d_spurious_valid: got out_valid=1 expected 0", w);
            end
            if (iv && ir) begin
                q.push_back(ref_mul(w, a, b, sgn));
                issued++;
            end
            if (ov && ordy && q.size() > 0) begin
                checks++;
                if (prod !== q[0]) begin
                    errors++; $display("FAIL rand_w%0d_product: got %h expected %h", w, prod, q[0]);
                end
                void'(q.pop_front());
                done++;
            end
            step(); cyc++;
        end
        iv = 1'b0; ordy = 1'b1;
        checks++;
        if (issued != done || done != num) begin
            errors++;
            $display("FAIL rand_w%0d_counts: got accepts=%0d handshakes=%0d expected %0d each", w, issued, done, num);
        end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_unsigned4();
        test_signed4();
        test_backpressure();
        test_reset_midop();
        test_width8();
        test_random(1'b0, 500);
        test_random(1'b1, 500);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
